// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store execution (LB/LH/LW/LBU/LHU/SB/SH/SW) between
//            the execute stage and data memory. Computes the effective
//            address, checks alignment and funct3 legality, and runs a
//            request/acknowledge handshake with timeout. Stores get byte-lane
//            steering; loads get lane extraction and sign/zero extension, and
//            the result goes to the register-file write port.
// Ports    : clk, reset (sync, active-high)
//            start/is_store/funct3/base/offset/store_data/rd : request in
//            busy/done/error                                 : status out
//            mem_req/mem_we/mem_addr/mem_be/mem_wdata        : memory request
//            mem_rdata/mem_ack                               : memory response
//            rf_write_enable/rf_addr/rf_write_data           : reg_file write
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rf_write_enable,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_write_data
);

    // Counter is wide enough to hold MEM_TIMEOUT itself.
    localparam int                 c_cnt_w   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                 r_is_store, w_is_store_nxt;
    logic [2:0]           r_funct3, w_funct3_nxt;
    logic [1:0]           r_ofs, w_ofs_nxt;
    logic [4:0]           r_rd, w_rd_nxt;

    logic                 w_busy_nxt, w_done_nxt, w_error_nxt;
    logic                 w_mem_req_nxt, w_mem_we_nxt;
    logic [31:0]          w_mem_addr_nxt, w_mem_wdata_nxt;
    logic [3:0]           w_mem_be_nxt;
    logic                 w_rf_we_nxt;
    logic [4:0]           w_rf_addr_nxt;
    logic [31:0]          w_rf_data_nxt;

    // Request decode, evaluated on the incoming request fields
    logic [31:0]          w_ea;
    logic [1:0]           w_ofs;
    logic                 w_bad_f3;
    logic                 w_misaligned;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;

    // Load result extraction, evaluated on latched request fields
    logic [7:0]           w_ld_byte;
    logic [15:0]          w_ld_half;
    logic [31:0]          w_ld_data;

    assign w_cnt_inc = r_cnt + c_cnt_w'(1);

    always_comb begin
        w_ea    = base + offset;
        w_ofs   = w_ea[1:0];
        if (is_store) begin
            w_bad_f3 = (funct3 > 3'd2);
        end else begin
            w_bad_f3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        // funct3[1:0] encodes access size: 0 byte, 1 half, 2 word.
        w_misaligned = ((funct3[1:0] == 2'd1) && w_ofs[0]) ||
                       ((funct3[1:0] == 2'd2) && (w_ofs != 2'b00));

        // Loads always read the full word; lane selection happens on return.
        w_be    = 4'b1111;
        w_wdata = store_data;
        if (is_store) begin
            case (funct3[1:0])
                2'd0: begin
                    w_be    = 4'b0001 << w_ofs;
                    w_wdata = {4{store_data[7:0]}};
                end
                2'd1: begin
                    w_be    = w_ofs[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    always_comb begin
        w_ld_byte = mem_rdata[{r_ofs, 3'b000} +: 8];
        w_ld_half = mem_rdata[{r_ofs[1], 4'b0000} +: 16];
        case (r_funct3)
            3'd0:    w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'd1:    w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'd4:    w_ld_data = {24'd0, w_ld_byte};
            3'd5:    w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_store_nxt  = r_is_store;
        w_funct3_nxt    = r_funct3;
        w_ofs_nxt       = r_ofs;
        w_rd_nxt        = r_rd;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_error_nxt     = 1'b0;
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = mem_we;
        w_mem_addr_nxt  = mem_addr;
        w_mem_be_nxt    = mem_be;
        w_mem_wdata_nxt = mem_wdata;
        w_rf_we_nxt     = 1'b0;
        w_rf_addr_nxt   = rf_addr;
        w_rf_data_nxt   = rf_write_data;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_is_store_nxt = is_store;
                    w_funct3_nxt   = funct3;
                    w_ofs_nxt      = w_ofs;
                    w_rd_nxt       = rd;
                    w_busy_nxt     = 1'b1;
                    w_cnt_nxt      = '0;
                    if (w_bad_f3 || w_misaligned) begin
                        // Rejected request: report immediately, no bus access.
                        w_state_nxt = ST_FINISH;
                        w_done_nxt  = 1'b1;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_ACCESS;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = is_store;
                        w_mem_addr_nxt  = {w_ea[31:2], 2'b00};
                        w_mem_be_nxt    = w_be;
                        w_mem_wdata_nxt = w_wdata;
                    end
                end
            end

            ST_ACCESS: begin
                w_busy_nxt = 1'b1;
                if (mem_ack && mem_req) begin
                    w_state_nxt   = ST_FINISH;
                    w_done_nxt    = 1'b1;
                    w_rf_we_nxt   = !r_is_store && (r_rd != 5'd0);
                    w_rf_addr_nxt = r_rd;
                    w_rf_data_nxt = w_ld_data;
                end else if ((MEM_TIMEOUT != 0) && (w_cnt_inc == c_timeout)) begin
                    w_state_nxt = ST_FINISH;
                    w_done_nxt  = 1'b1;
                    w_error_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_mem_req_nxt = 1'b1;
                    if (MEM_TIMEOUT != 0) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_is_store      <= 1'b0;
            r_funct3        <= 3'd0;
            r_ofs           <= 2'd0;
            r_rd            <= 5'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= 32'd0;
            mem_be          <= 4'd0;
            mem_wdata       <= 32'd0;
            rf_write_enable <= 1'b0;
            rf_addr         <= 5'd0;
            rf_write_data   <= 32'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_is_store      <= w_is_store_nxt;
            r_funct3        <= w_funct3_nxt;
            r_ofs           <= w_ofs_nxt;
            r_rd            <= w_rd_nxt;
            busy            <= w_busy_nxt;
            done            <= w_done_nxt;
            error           <= w_error_nxt;
            mem_req         <= w_mem_req_nxt;
            mem_we          <= w_mem_we_nxt;
            mem_addr        <= w_mem_addr_nxt;
            mem_be          <= w_mem_be_nxt;
            mem_wdata       <= w_mem_wdata_nxt;
            rf_write_enable <= w_rf_we_nxt;
            rf_addr         <= w_rf_addr_nxt;
            rf_write_data   <= w_rf_data_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard testbench for load_store_unit. Stimulus queues the
//            expected memory request and completion of every transaction;
//            a monitor compares them against DUT outputs as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] base = 32'd0;
    logic [31:0] offset = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        busy, done, error, mem_req, mem_we, rf_write_enable;
    logic [31:0] mem_addr, mem_wdata, rf_write_data;
    logic [3:0]  mem_be;
    logic [4:0]  rf_addr;

    load_store_unit #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .base(base), .offset(offset), .store_data(store_data),
        .rd(rd), .busy(busy), .done(done), .error(error), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_write_enable(rf_write_enable), .rf_addr(rf_addr),
        .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cycle;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_wdata;
        int          len;
    } req_t;

    done_t done_q[$];
    req_t  req_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // ---------------- monitor ----------------
    req_t cur;
    int   req_len = 0;
    bit   prev_req = 1'b0;
    bit   in_req = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            done_q.delete();
            req_q.delete();
            prev_req = 1'b0;
            in_req   = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_mem_req: got mem_req=1 at cycle %0d, required none", cyc);
                    in_req = 1'b0;
                end else begin
                    cur = req_q.pop_front();
                    in_req = 1'b1;
                end
                req_len = 0;
            end
            if (mem_req && in_req) begin
                req_len++;
                vectors++;
                if (mem_addr !== cur.addr || mem_we !== cur.we || mem_be !== cur.be ||
                    (cur.chk_wdata && mem_wdata !== cur.wdata)) begin
                    miscompares++;
                    $display("FAIL mem_fields: got addr=%h we=%b be=%b wdata=%h, required addr=%h we=%b be=%b wdata=%h",
                             mem_addr, mem_we, mem_be, mem_wdata, cur.addr, cur.we, cur.be, cur.wdata);
                end
            end
            if (!mem_req && prev_req && in_req) begin
                vectors++;
                if (req_len != cur.len) begin
                    miscompares++;
                    $display("FAIL mem_req_len: got %0d cycles, required %0d", req_len, cur.len);
                end
                in_req = 1'b0;
            end
            prev_req = mem_req;

            if (done) begin
                vectors++;
                if (done_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, required none", cyc);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    if (error !== e.err || rf_write_enable !== e.we || cyc != e.cycle ||
                        (e.we && (rf_addr !== e.rd || rf_write_data !== e.data))) begin
                        miscompares++;
                        $display("FAIL completion: got err=%b we=%b rd=%0d data=%h cycle=%0d, required err=%b we=%b rd=%0d data=%h cycle=%0d",
                                 error, rf_write_enable, rf_addr, rf_write_data, cyc,
                                 e.err, e.we, e.rd, e.data, e.cycle);
                    end
                end
            end else if (rf_write_enable) begin
                vectors++; miscompares++;
                $display("FAIL rf_we_without_done: got rf_write_enable=1 done=0 at cycle %0d, required 0", cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            vectors++; miscompares++;
            $display("FAIL busy_timeout: got busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Reference model plus driver for one transaction. j is the ACCESS cycle
    // (1-based) in which mem_ack is presented; j > TO means it arrives too late.
    task automatic run_txn(input bit st, input bit [2:0] f3, input logic [31:0] b,
                           input logic [31:0] o, input logic [31:0] sd,
                           input logic [31:0] rdat, input logic [4:0] r,
                           input int j, input bit junk);
        logic [31:0] ea, sh, v;
        int          ofs, nbytes, c;
        bit          legal, rejected, timed_out;
        done_t       d;
        req_t        q;

        wait_idle();
        ea     = b + o;
        ofs    = int'(ea & 32'd3);
        nbytes = 1 << f3[1:0];
        legal  = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        rejected  = !legal || ((ofs % nbytes) != 0);
        timed_out = !rejected && (j > TO);

        sh = rdat >> (8 * ofs);
        case (f3)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd4: v = sh & 32'hFF;
            3'd5: v = sh & 32'hFFFF;
            default: v = rdat;
        endcase

        c       = cyc;
        d.err   = rejected || timed_out;
        d.we    = !st && !d.err && (r != 5'd0);
        d.rd    = r;
        d.data  = v;
        d.cycle = rejected ? c + 1 : (timed_out ? c + TO + 1 : c + j + 1);
        done_q.push_back(d);

        if (!rejected) begin
            q.addr = ea & ~32'd3;
            q.we   = st;
            if (!st)              q.be = 4'hF;
            else if (nbytes == 1) q.be = 4'(1 << ofs);
            else if (nbytes == 2) q.be = (ofs >= 2) ? 4'hC : 4'h3;
            else                  q.be = 4'hF;
            if (nbytes == 1)      q.wdata = (sd & 32'hFF) * 32'h01010101;
            else if (nbytes == 2) q.wdata = (sd & 32'hFFFF) * 32'h00010001;
            else                  q.wdata = sd;
            q.chk_wdata = st;
            q.len       = timed_out ? TO : j;
            req_q.push_back(q);
        end

        start = 1'b1; is_store = st; funct3 = f3; base = b; offset = o;
        store_data = sd; rd = r;
        tick();
        // Cycle c+1: optionally present a request that must be ignored.
        start = junk;
        if (junk) begin
            is_store = 1'($urandom_range(0, 1));
            funct3   = 3'($urandom_range(0, 7));
            base     = $urandom;
            rd       = 5'($urandom_range(1, 31));
        end
        for (int k = 1; k < j; k++) begin
            tick();
            start = 1'b0;
        end
        mem_ack   = 1'b1;
        mem_rdata = rdat;
        tick();
        mem_ack   = 1'b0;
        start     = 1'b0;
        mem_rdata = $urandom;
    endtask

    // Reset asserted while a load sits in ACCESS, then an ack arrives late.
    task automatic run_reset_mid_access();
        req_t q;
        wait_idle();
        q.addr = 32'h0000_3000; q.we = 1'b0; q.be = 4'hF; q.wdata = '0;
        q.chk_wdata = 1'b0; q.len = 2;
        req_q.push_back(q);
        start = 1'b1; is_store = 1'b0; funct3 = 3'd2; base = 32'h0000_3000;
        offset = 32'd0; rd = 5'd9;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_mid_access_outputs", {busy, done, mem_req, rf_write_enable}, 4'b0000);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_ignored", {busy, done, mem_req, rf_write_enable}, 4'b0000);
        tick();
        chk("late_ack_no_done", {done, rf_write_enable}, 2'b00);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit          st;
        bit [2:0]    f3;
        logic [31:0] b, o, mask;

        reset = 1'b1;
        repeat (3) tick();
        chk("reset_state",
            {busy, done, error, mem_req, mem_we, mem_addr, mem_be, rf_write_enable, rf_addr},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 5'd0});
        chk("reset_data", {mem_wdata, rf_write_data}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed cases
        run_txn(1'b0, 3'd2, 32'h1000, 32'd4, 32'd0, 32'hDEADBEEF, 5'd5, 1, 1'b0);
        run_txn(1'b0, 3'd0, 32'h1000, 32'd3, 32'd0, 32'h80FF1234, 5'd6, 1, 1'b0);
        run_txn(1'b0, 3'd4, 32'h1000, 32'd3, 32'd0, 32'h80FF1234, 5'd7, 2, 1'b0);
        run_txn(1'b1, 3'd1, 32'h2000, 32'd2, 32'h0000ABCD, 32'd0, 5'd1, 1, 1'b0);
        run_txn(1'b0, 3'd2, 32'h1000, 32'd2, 32'd0, 32'd0, 5'd3, 1, 1'b0);
        run_txn(1'b0, 3'd3, 32'h1000, 32'd0, 32'd0, 32'd0, 5'd3, 2, 1'b1);
        run_txn(1'b0, 3'd2, 32'h4000, 32'd0, 32'd0, 32'h55AA55AA, 5'd8, 6, 1'b1);
        run_txn(1'b0, 3'd2, 32'h4000, 32'd8, 32'd0, 32'hCAFEF00D, 5'd8, TO, 1'b0);
        run_reset_mid_access();
        run_txn(1'b0, 3'd2, 32'h5000, 32'd0, 32'd0, 32'h01020304, 5'd0, 1, 1'b0);
        run_txn(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_00A5, 32'd0, 5'd2, 3, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (st) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            b = $urandom;
            o = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
            mask = (f3[1:0] == 2'd0) ? 32'd0 : ((f3[1:0] == 2'd1) ? 32'd1 : 32'd3);
            if ($urandom_range(0, 3) != 0) o = o - ((b + o) & mask);
            run_txn(st, f3, b, o, $urandom, $urandom, 5'($urandom_range(0, 31)),
                    int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (4) tick();
        chk("queues_drained", 64'(done_q.size() + req_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
